// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-2:0]  r;
    logic          bw;
    logic [CW-1:0] cnt;

    logic          x;
    logic          y;
    logic          d;
    logic          bw_next;
    logic [N-1:0]  r_next;

    // r keeps only the upper N-1 result bits; the bit shifted out on the last step lands directly in diff
    assign x       = sa[0];
    assign y       = sb[0];
    assign d       = x ^ y ^ bw;
    assign bw_next = (~x & y) | (~(x ^ y) & bw);
    assign r_next  = {d, r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            r          <= '0;
            bw         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        r     <= '0;
                        bw    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    r  <= r_next[N-1:1];
                    bw <= bw_next;
                    // Results are published on the same edge that enters DONE
                    if (cnt == LAST) begin
                        diff       <= r_next;
                        borrow_out <= bw_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= bw ^ bw_next;
`endif
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing A − B one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-operation companion to the team's full-adder cell and is used where area matters more than latency. A start/busy/done handshake lets a controller launch one operation and collect the difference and final borrow.

## Interface
- N, default 8, operand and result width in bits; legal range N ≥ 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- a  input  N  minuend; sampled on the accepted start edge only.
- b  input  N  subtrahend; sampled on the accepted start edge only.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse when diff and borrow_out are valid.
- diff  output  N  A − B modulo 2^N; held until the next done.
- borrow_out  output  1  final borrow; 1 when unsigned A < B; held until the next done.
- ovf  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

## Operation
- States are IDLE, SHIFT and DONE. Reset enters IDLE.
- IDLE: when start=1, load shift registers SA←a and SB←b, clear the borrow flop bw=0, clear the bit counter cnt=0, then go to SHIFT. When start=0, stay in IDLE.
- SHIFT, once per cycle:
  - Let x=SA[0] and y=SB[0].
  - Compute d = x^y^bw.
  - Compute bw_next = (~x&y) | (~(x^y)&bw).
  - Shift d into the MSB of the result register R, and shift R, SA and SB right by one.
  - Set bw ← bw_next and cnt ← cnt+1.
  - When cnt==N-1, this is the last bit; go to DONE.
- DONE (one cycle):
  - diff ← R, borrow_out ← bw, done=1.
  - Go to IDLE.
- cnt is $clog2(N) bits wide and never wraps past N-1.
- start while busy=1 is ignored, including in the DONE cycle. No queuing.
- Changes on a/b after the accepted start have no effect.
- Reset values: busy=0, done=0, diff=0, borrow_out=0, ovf=0, state IDLE, and all internal registers 0.
- Reset mid-operation aborts immediately. No done is produced, and diff and borrow_out return to 0.

## Timing
- Start is accepted at rising edge T0, with state IDLE→SHIFT.
- Bit i is processed at edge T0+1+i, for i=0..N-1. The state is SHIFT during cycles T0+1 to T0+N.
- The state is DONE during cycle T0+N+1. done is high for that cycle only, and diff, borrow_out and ovf update at its start edge.
- Latency from start sampled to done high: N+1 cycles. done is registered, never combinational from start.
- The earliest next accepted start is the edge ending the DONE cycle plus one, when the state is back in IDLE. Throughput is one operation per N+2 cycles.
- busy rises the cycle after the accepted start and falls with done.

## Configuration
- Macro: SERIAL_SUB_OVF_EN.
- Defined: the ovf port exists.
  - During the last SHIFT cycle (cnt==N-1), latch ovf_int = bw ^ bw_next, i.e. borrow into the MSB XOR borrow out of the MSB.
  - ovf ← ovf_int in DONE, then held until the next done.
  - ovf is reset to 0.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- Unsigned no-borrow case: N=8, a=100, b=37, start pulse. Required: done exactly 9 cycles after the start edge, diff=63, borrow_out=0, busy high for 9 cycles.
- Borrow case: a=5, b=9. Required: diff=8'hFC, borrow_out=1. a=8'hFF, b=8'hFF: required diff=0, borrow_out=0.
- Start ignored while busy: issue a=10, b=3, then assert start again with a=1, b=2 at cycles T0+3 and at the DONE cycle. Required: a single done, diff=7, and the outputs stay 7 until the next accepted start.
- Reset mid-operation: assert rst_n=0 at cycle T0+4. Required: busy=0, done=0, diff=0 and borrow_out=0 asynchronously. After release, a fresh start with a=20, b=20 gives diff=0 after N+1 cycles.
- Back-to-back operations: assert start on the first IDLE cycle after done, with a=8'h80 then b=8'h01. Required: diff=8'h7F, borrow_out=0. With SERIAL_SUB_OVF_EN, ovf=1. With a=3, b=5, ovf=0.
- Output hold: after done, toggle a and b with start=0 for 20 cycles. Required: diff and borrow_out unchanged, and done stays 0.
